matmul_tile_scheduler: RTL and testbench

//  Sequences the 4x4 systolic matmul over an (M x K) * (K x N) problem of 4x4 tiles held in the A/B/C BRAMs.

---
 rtl/matmul_tile_scheduler_if.sv | 33 +++
 rtl/matmul_tile_scheduler.sv | 170 +++++++++++++++++
 tb/tb_matmul_tile_scheduler.sv | 296 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/matmul_tile_scheduler_if.sv
// Tile handshake and address bus between the scheduler
// and the 4x4 systolic array.
interface matmul_tile_scheduler_if #(
  parameter int AWIDTH = 11
);
  logic              start_mat_mul;
  logic              done_mat_mul;
  logic              pe_reset;
  logic [AWIDTH-1:0] address_mat_a;
  logic [AWIDTH-1:0] address_mat_b;
  logic [AWIDTH-1:0] address_mat_c;
  logic              c_store_en;

  modport master (
    output start_mat_mul,
    input  done_mat_mul,
    output pe_reset,
    output address_mat_a,
    output address_mat_b,
    output address_mat_c,
    output c_store_en
  );

  modport slave (
    input  start_mat_mul,
    output done_mat_mul,
    input  pe_reset,
    input  address_mat_a,
    input  address_mat_b,
    input  address_mat_c,
    input  c_store_en
  );
endinterface

// File: rtl/matmul_tile_scheduler.sv
// Walks the m/n/k tile loops (k innermost) and drives one
// systolic-array handshake per 4x4 tile with its addresses.
module matmul_tile_scheduler #(
  parameter int AWIDTH = 11,
  parameter int CNTW   = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              clear_done,
  input  logic [CNTW-1:0]   num_tiles_m,
  input  logic [CNTW-1:0]   num_tiles_n,
  input  logic [CNTW-1:0]   num_tiles_k,
  input  logic [AWIDTH-1:0] base_a,
  input  logic [AWIDTH-1:0] base_b,
  input  logic [AWIDTH-1:0] base_c,
  input  logic [AWIDTH-1:0] a_m_step,
  input  logic [AWIDTH-1:0] a_k_step,
  input  logic [AWIDTH-1:0] b_k_step,
  input  logic [AWIDTH-1:0] b_n_step,
  input  logic [AWIDTH-1:0] c_m_step,
  input  logic [AWIDTH-1:0] c_n_step,
  matmul_tile_scheduler_if.master mm,
  output logic              busy,
  output logic              done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PE_CLR,
    S_ISSUE,
    S_WAIT,
    S_ADVANCE,
    S_DONE
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [CNTW-1:0]   r_num_m, r_num_n, r_num_k;
  logic [CNTW-1:0]   r_m, r_n, r_k;
  logic [AWIDTH-1:0] r_base_b;
  logic [AWIDTH-1:0] r_a_ms, r_a_ks, r_b_ks;
  logic [AWIDTH-1:0] r_b_ns, r_c_ms, r_c_ns;
  logic [AWIDTH-1:0] r_a_row, r_b_col, r_c_row;
  logic [AWIDTH-1:0] r_a, r_b, r_c;

  logic w_cnt_ok;
  logic w_k_last, w_n_last, w_m_last;
  logic w_active;
  logic w_load;

  assign w_cnt_ok = (num_tiles_m != '0) &&
                    (num_tiles_n != '0) &&
                    (num_tiles_k != '0);
  assign w_k_last = (r_k == r_num_k - 1'b1);
  assign w_n_last = (r_n == r_num_n - 1'b1);
  assign w_m_last = (r_m == r_num_m - 1'b1);
  assign w_load   = (r_state == S_IDLE) && start;

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:
        if (start) w_next = w_cnt_ok ? S_PE_CLR : S_DONE;
      S_PE_CLR:
        w_next = S_ISSUE;
      S_ISSUE:
        w_next = S_WAIT;
      S_WAIT:
        if (mm.done_mat_mul) w_next = S_ADVANCE;
      S_ADVANCE:
        if (!w_k_last)             w_next = S_ISSUE;
        else if (w_n_last && w_m_last) w_next = S_DONE;
        else                       w_next = S_PE_CLR;
      S_DONE:
        if (clear_done) w_next = S_IDLE;
      default:
        w_next = S_IDLE;
    endcase
  end

  // Counters and addresses only move in ADVANCE, so the
  // tile outputs hold steady from ISSUE through ADVANCE.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_num_m  <= '0;
      r_num_n  <= '0;
      r_num_k  <= '0;
      r_m      <= '0;
      r_n      <= '0;
      r_k      <= '0;
      r_base_b <= '0;
      r_a_ms   <= '0;
      r_a_ks   <= '0;
      r_b_ks   <= '0;
      r_b_ns   <= '0;
      r_c_ms   <= '0;
      r_c_ns   <= '0;
      r_a_row  <= '0;
      r_b_col  <= '0;
      r_c_row  <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_c      <= '0;
    end else if (w_load) begin
      r_num_m  <= num_tiles_m;
      r_num_n  <= num_tiles_n;
      r_num_k  <= num_tiles_k;
      r_m      <= '0;
      r_n      <= '0;
      r_k      <= '0;
      r_base_b <= base_b;
      r_a_ms   <= a_m_step;
      r_a_ks   <= a_k_step;
      r_b_ks   <= b_k_step;
      r_b_ns   <= b_n_step;
      r_c_ms   <= c_m_step;
      r_c_ns   <= c_n_step;
      r_a_row  <= base_a;
      r_b_col  <= base_b;
      r_c_row  <= base_c;
      r_a      <= base_a;
      r_b      <= base_b;
      r_c      <= base_c;
    end else if (r_state == S_ADVANCE) begin
      if (!w_k_last) begin
        r_k <= r_k + 1'b1;
        r_a <= r_a + r_a_ks;
        r_b <= r_b + r_b_ks;
      end else if (!w_n_last) begin
        r_k     <= '0;
        r_n     <= r_n + 1'b1;
        r_b_col <= r_b_col + r_b_ns;
        r_a     <= r_a_row;
        r_b     <= r_b_col + r_b_ns;
        r_c     <= r_c + r_c_ns;
      end else if (!w_m_last) begin
        r_k     <= '0;
        r_n     <= '0;
        r_m     <= r_m + 1'b1;
        r_a_row <= r_a_row + r_a_ms;
        r_a     <= r_a_row + r_a_ms;
        r_b_col <= r_base_b;
        r_b     <= r_base_b;
        r_c_row <= r_c_row + r_c_ms;
        r_c     <= r_c_row + r_c_ms;
      end
    end
  end

  assign w_active = (r_state != S_IDLE) &&
                    (r_state != S_DONE);

  assign busy             = w_active;
  assign done             = (r_state == S_DONE);
  assign mm.pe_reset      = (r_state == S_PE_CLR);
  assign mm.start_mat_mul = (r_state == S_ISSUE) ||
                            (r_state == S_WAIT);
  assign mm.address_mat_a = r_a;
  assign mm.address_mat_b = r_b;
  assign mm.address_mat_c = r_c;
  assign mm.c_store_en    = w_active && w_k_last;

endmodule

// File: tb/tb_matmul_tile_scheduler.sv
// Randomized scoreboard bench for matmul_tile_scheduler
// against a loop-nest reference of the tile sequence.
module tb_matmul_tile_scheduler;
  localparam int AW = 11;
  localparam int CW = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;
  logic start;
  logic clear_done;
  logic [CW-1:0] nm, nn, nk;
  logic [AW-1:0] ba, bb, bc;
  logic [AW-1:0] ams, aks, bks, bns, cms, cns;
  logic busy, done;

  matmul_tile_scheduler_if #(.AWIDTH(AW)) mm_if ();

  matmul_tile_scheduler #(.AWIDTH(AW), .CNTW(CW)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .clear_done  (clear_done),
    .num_tiles_m (nm),
    .num_tiles_n (nn),
    .num_tiles_k (nk),
    .base_a      (ba),
    .base_b      (bb),
    .base_c      (bc),
    .a_m_step    (ams),
    .a_k_step    (aks),
    .b_k_step    (bks),
    .b_n_step    (bns),
    .c_m_step    (cms),
    .c_n_step    (cns),
    .mm          (mm_if.master),
    .busy        (busy),
    .done        (done)
  );

  typedef struct packed {
    logic [AW-1:0] a;
    logic [AW-1:0] b;
    logic [AW-1:0] c;
    logic          st;
    logic          clr;
  } tile_t;

  tile_t exp_q[$];
  int errs   = 0;
  int checks = 0;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errs++;
      $display("FAIL %s: got %0h want %0h",
               name, act, req);
    end
  endtask

  // Array model: answers done_mat_mul after resp_dly cycles
  int   resp_dly  = 2;
  int   wcnt      = 0;
  logic resp_done = 1'b0;
  logic spur      = 1'b0;
  assign mm_if.done_mat_mul = resp_done | spur;

  always @(negedge clk) begin
    if (!mm_if.start_mat_mul) begin
      wcnt      = 0;
      resp_done = 1'b0;
    end else begin
      if (wcnt >= resp_dly) resp_done = 1'b1;
      wcnt++;
    end
  end

  // Monitor: one tile per rising edge of start_mat_mul
  logic  prev_smm = 1'b0;
  int    pe_seen  = 0;
  int    pe_total = 0;
  bit    have     = 0;
  tile_t cur;

  always @(negedge clk) begin
    if (reset) begin
      prev_smm = 1'b0;
      pe_seen  = 0;
      have     = 0;
    end else begin
      if (mm_if.pe_reset) begin
        pe_seen++;
        pe_total++;
      end
      if (mm_if.start_mat_mul && !prev_smm) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_tile", 1, 0);
          have = 0;
        end else begin
          cur  = exp_q.pop_front();
          have = 1;
          chk("pe_reset_pulses", pe_seen,
              {31'd0, cur.clr});
          pe_seen = 0;
        end
      end
      if (mm_if.start_mat_mul && have) begin
        chk("addr_a", mm_if.address_mat_a, cur.a);
        chk("addr_b", mm_if.address_mat_b, cur.b);
        chk("addr_c", mm_if.address_mat_c, cur.c);
        chk("c_store_en", mm_if.c_store_en, cur.st);
      end
      prev_smm = mm_if.start_mat_mul;
    end
  end

  function automatic logic [AW-1:0] wrap(input int v);
    return AW'(v);
  endfunction

  task automatic push_tiles(
    input int m_, input int n_, input int k_,
    input logic [AW-1:0] a0, input logic [AW-1:0] b0,
    input logic [AW-1:0] c0,
    input logic [AW-1:0] am, input logic [AW-1:0] ak,
    input logic [AW-1:0] bk, input logic [AW-1:0] bn,
    input logic [AW-1:0] cm, input logic [AW-1:0] cn);
    tile_t t;
    for (int m = 0; m < m_; m++)
      for (int n = 0; n < n_; n++)
        for (int k = 0; k < k_; k++) begin
          t.a   = wrap(int'(a0) + m*int'(am) + k*int'(ak));
          t.b   = wrap(int'(b0) + n*int'(bn) + k*int'(bk));
          t.c   = wrap(int'(c0) + m*int'(cm) + n*int'(cn));
          t.st  = (k == k_ - 1);
          t.clr = (k == 0);
          exp_q.push_back(t);
        end
  endtask

  task automatic run_job(
    input int m_, input int n_, input int k_,
    input logic [AW-1:0] a0, input logic [AW-1:0] b0,
    input logic [AW-1:0] c0,
    input logic [AW-1:0] am, input logic [AW-1:0] ak,
    input logic [AW-1:0] bk, input logic [AW-1:0] bn,
    input logic [AW-1:0] cm, input logic [AW-1:0] cn,
    input bit cs_start);
    int pe0;
    int cyc;
    bit empty;
    empty = (m_ == 0) || (n_ == 0) || (k_ == 0);
    @(negedge clk);
    nm = CW'(m_); nn = CW'(n_); nk = CW'(k_);
    ba = a0; bb = b0; bc = c0;
    ams = am; aks = ak; bks = bk;
    bns = bn; cms = cm; cns = cn;
    push_tiles(m_, n_, k_, a0, b0, c0,
               am, ak, bk, bn, cm, cn);
    pe0   = pe_total;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    if (empty) begin
      chk("empty_done", done, 1);
      chk("empty_busy", busy, 0);
    end else begin
      chk("pe_reset_cycle1", mm_if.pe_reset, 1);
      chk("smm_cycle1", mm_if.start_mat_mul, 0);
      chk("busy_running", busy, 1);
    end
    ba  = AW'($urandom); bb  = AW'($urandom);
    bc  = AW'($urandom); ams = AW'($urandom);
    aks = AW'($urandom); bks = AW'($urandom);
    bns = AW'($urandom); cms = AW'($urandom);
    cns = AW'($urandom);
    @(negedge clk);
    if (!empty) chk("smm_cycle2", mm_if.start_mat_mul, 1);
    cyc = 0;
    while (!done && cyc < 3000) begin
      @(negedge clk);
      cyc++;
    end
    chk("job_done", done, 1);
    chk("done_not_busy", busy, 0);
    chk("tiles_left", exp_q.size(), 0);
    chk("pe_reset_total", pe_total - pe0,
        empty ? 0 : m_ * n_);
    exp_q.delete();
    @(negedge clk);
    chk("done_held", done, 1);
    clear_done = 1'b1;
    start      = cs_start;
    @(negedge clk);
    clear_done = 1'b0;
    start      = 1'b0;
    chk("cleared_done", done, 0);
    chk("cleared_busy", busy, 0);
    @(negedge clk);
    chk("idle_after_clear", busy | done, 0);
  endtask

  initial begin
    int cyc;
    reset = 1'b1; start = 1'b0; clear_done = 1'b0;
    nm = '0; nn = '0; nk = '0;
    ba = '0; bb = '0; bc = '0;
    ams = '0; aks = '0; bks = '0;
    bns = '0; cms = '0; cns = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_smm", mm_if.start_mat_mul, 0);
    chk("rst_pe", mm_if.pe_reset, 0);
    chk("rst_addr_a", mm_if.address_mat_a, 0);
    chk("rst_addr_c", mm_if.address_mat_c, 0);
    chk("rst_store", mm_if.c_store_en, 0);
    reset = 1'b0;

    spur = 1'b1;
    @(negedge clk);
    spur = 1'b0;
    chk("spurious_done_idle", busy | done, 0);

    resp_dly = 5;
    run_job(1, 1, 1, 11'h010, 11'h100, 11'h200,
            0, 0, 0, 0, 0, 0, 1);
    resp_dly = 2;
    run_job(1, 1, 2, 11'h010, 11'h100, 11'h200,
            0, 4, 4, 0, 0, 0, 0);
    run_job(2, 2, 1, 11'h010, 11'h100, 11'h200,
            8, 0, 0, 4, 8, 4, 0);
    run_job(1, 0, 1, 11'h010, 11'h100, 11'h200,
            0, 0, 0, 0, 0, 0, 0);
    run_job(1, 1, 2, 11'h7FC, 11'h100, 11'h200,
            0, 8, 0, 0, 0, 0, 0);

    // Abort a job while the array holds the handshake
    resp_dly = 1000;
    @(negedge clk);
    nm = 2; nn = 2; nk = 2;
    ba = 11'h020; bb = 11'h140; bc = 11'h280;
    ams = 1; aks = 2; bks = 3;
    bns = 4; cms = 5; cns = 6;
    push_tiles(1, 1, 1, 11'h020, 11'h140, 11'h280,
               0, 0, 0, 0, 0, 0);
    exp_q[0].st = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 0;
    while (!mm_if.start_mat_mul && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    chk("abort_smm_rise", mm_if.start_mat_mul, 1);
    repeat (2) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("start_in_wait_busy", busy, 1);
    chk("start_in_wait_smm", mm_if.start_mat_mul, 1);
    chk("start_in_wait_pe", mm_if.pe_reset, 0);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("abort_smm", mm_if.start_mat_mul, 0);
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    exp_q.delete();
    @(negedge clk);
    chk("abort_stays_idle", busy | done, 0);

    for (int j = 0; j < 12; j++) begin
      int m_, n_, k_;
      m_ = $urandom_range(1, 3);
      n_ = $urandom_range(1, 3);
      k_ = $urandom_range(1, 3);
      if ($urandom_range(0, 5) == 0) n_ = 0;
      resp_dly = $urandom_range(0, 4);
      run_job(m_, n_, k_,
              AW'($urandom), AW'($urandom), AW'($urandom),
              AW'($urandom), AW'($urandom), AW'($urandom),
              AW'($urandom), AW'($urandom), AW'($urandom),
              bit'($urandom_range(0, 1)));
    end

    $display("Result: errors=%0d of %0d checks",
             errs, checks);
    $finish;
  end
endmodule
